pwm_capture: RTL

//   Receive side of the team's PWM link: measures the high time and period of an external
//   PWM waveform, e.g. the pwm generator output driving the coil charge stage, fed back in.

---
 rtl/pwm_capture.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM capture: synchronises an asynchronous PWM input and measures high time and period
// between successive rising edges, with a sticky timeout for a stuck or dead line.
module pwm_capture #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TIMEOUT     = 1000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] high_time,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [WIDTH-1:0] TO_VAL = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       w_cnt_nxt;
    logic [WIDTH-1:0]       r_high_cap;
    logic                   w_cap_ld;
    logic                   w_report;
    logic                   w_to_set;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;
    assign level  = w_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_s_d  <= w_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // In LOW a rise takes priority over reaching TIMEOUT, so a period of exactly TIMEOUT still reports.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == TO_VAL) ? r_cnt : r_cnt + ONE;
        w_cap_ld    = 1'b0;
        w_report    = 1'b0;
        w_to_set    = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = ONE;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        w_state_nxt = LOW;
                        w_cap_ld    = 1'b1;
                    end else if (r_cnt == TO_VAL) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_to_set    = 1'b1;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = ONE;
                        w_report    = 1'b1;
                    end else if (r_cnt == TO_VAL) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_to_set    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_high_cap <= '0;
            high_time  <= '0;
            period     <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            valid <= w_report;
            if (w_cap_ld) begin
                r_high_cap <= r_cnt;
            end
            if (w_report) begin
                period    <= r_cnt;
                high_time <= r_high_cap;
                timeout   <= 1'b0;
            end else if (w_to_set) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
